ti_node_fetch: RTL and testbench
================================

// Module: ti_node_fetch
// PURPOSE
// - Multi-word fetch engine for the T&I unit: turns one {addr, size} fetch into per-word cache requests.
// - Used for BVH node (8 words), tri index (1 word) and triangle (12 words) fetches.
// - Reassembles out-of-order 32-bit responses into one wide buffer and pulses valid_out when done.
// - Sits between the T&I traversal FSM (upstream) and one RCACHE request port (downstream).
// PARAMETERS
// ADDR_WIDTH       32  byte address width
// WORD_WIDTH       32  cache data word width; word stride is 4 bytes
// MAX_WORDS        12  largest fetch in words (384-bit triangle node)
// MAX_OUTSTANDING  4   max in-flight cache requests
// TAG_WIDTH        5   = $clog2(MAX_WORDS)+1; MSB = epoch bit, LSBs = word slot
// PORTS
// clk            in   1                     clock
// reset          in   1                     sync, active-high
// start          in   1                     fetch request; accepted only when ready=1
// addr           in   ADDR_WIDTH            byte base address; addr[1:0] ignored (forced 0)
// size           in   $clog2(MAX_WORDS+1)   words to fetch
// ready          out  1                     engine idle, start will be accepted
// data_out       out  MAX_WORDS*WORD_WIDTH  word i at [i*32 +: 32]; unfetched words 0
// valid_out      out  1                     one-cycle pulse: data_out complete
// mem_req_valid  out  1                     cache read request valid
// mem_req_addr   out  ADDR_WIDTH            word-aligned request address
// mem_req_tag    out  TAG_WIDTH             {epoch, word slot}
// mem_req_ready  in   1                     cache accepts request
// mem_rsp_valid  in   1                     cache response valid
// mem_rsp_data   in   WORD_WIDTH            response word
// mem_rsp_tag    in   TAG_WIDTH             echoed request tag
// mem_rsp_ready  out  1                     always 1 (responses never stalled)
// BEHAVIOUR
// - Reset: state IDLE, ready=1, valid_out=0, mem_req_valid=0, data_out=0, epoch=0, counters 0.
// - FSM IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
// - IDLE: on start, latch addr&~3, clamp size to MAX_WORDS, clear data_out and received mask, toggle epoch.
//   size==0 -> DONE directly, no requests issued.
// - ISSUE: issue word i = 0..size-1 in order.
//   mem_req_addr = base + 4*i (mod 2^ADDR_WIDTH, wraps), tag = {epoch, i}.
//   mem_req_valid=1 only while outstanding < MAX_OUTSTANDING.
//   addr/tag held stable until mem_req_ready. Leave to WAIT after the last handshake.
// - WAIT: -> DONE once all size words are received.
// - DONE: valid_out=1 for exactly this cycle, then IDLE.
//   data_out held until the next accepted start; ready=1 again the cycle after DONE.
// - Responses: accepted every cycle. Tag epoch == current epoch and slot < size -> write slot, set mask bit, outstanding--.
//   Mismatched epoch (stale, e.g. pre-reset) or slot >= size -> dropped, no count change.
//   Duplicate response to an already-set slot: data ignored, not counted (protocol violation, assertion).
// - Same cycle req handshake + rsp accept: outstanding unchanged. Out-of-order responses fully supported.
// - Latency, always-ready cache, 1-cycle rsp, MAX_OUTSTANDING not limiting:
//   start @T, first req @T+1, last req @T+size, valid_out @T+size+2.
// - start while ready=0: ignored. Reset mid-fetch: abort to IDLE, outstanding=0, epoch=0.
//   In-flight responses are then dropped by epoch/idle checks (IDLE accepts no data).
// TESTING
// - size=8, addr=0x1000, cache ready, in-order 1-cycle rsp data=0xA0+i -> reqs 0x1000..0x101C tags 0..7;
//   valid_out @T+10; data_out[i*32+:32]=0xA0+i.
// - size=12, rsps in reverse order, MAX_OUTSTANDING=4 -> never >4 in flight; all 12 words placed by slot; single valid_out pulse.
// - size=1, addr=0x2003 -> one req addr 0x2000; size=0 -> no reqs, valid_out @T+1, data_out=0.
// - mem_req_ready low 5 cycles mid-ISSUE -> addr/tag stable while stalled; no dropped or repeated word.
// - reset at word 3 of 8, old-epoch rsps after reset, then new size=2 fetch -> stale rsps dropped; new data_out correct.
// - addr=0xFFFFFFF8, size=4 -> req addrs wrap: 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4.

Source files
------------

// File: rtl/ti_node_fetch.sv
// ti_node_fetch: turns one {addr, size} fetch into per-word cache reads and
// reassembles the tagged, possibly out-of-order responses into one wide buffer.
module ti_node_fetch #(
   parameter int ADDR_WIDTH      = 32,
   parameter int WORD_WIDTH      = 32,
   parameter int MAX_WORDS       = 12,
   parameter int MAX_OUTSTANDING = 4,
   parameter int TAG_WIDTH       = $clog2(MAX_WORDS) + 1
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              start,
   input  logic [ADDR_WIDTH-1:0]             addr,
   input  logic [$clog2(MAX_WORDS+1)-1:0]    size,
   output logic                              ready,
   output logic [MAX_WORDS*WORD_WIDTH-1:0]   data_out,
   output logic                              valid_out,
   output logic                              mem_req_valid,
   output logic [ADDR_WIDTH-1:0]             mem_req_addr,
   output logic [TAG_WIDTH-1:0]              mem_req_tag,
   input  logic                              mem_req_ready,
   input  logic                              mem_rsp_valid,
   input  logic [WORD_WIDTH-1:0]             mem_rsp_data,
   input  logic [TAG_WIDTH-1:0]              mem_rsp_tag,
   output logic                              mem_rsp_ready
);

   localparam int SIZE_WIDTH = $clog2(MAX_WORDS + 1);
   localparam int SLOT_WIDTH = TAG_WIDTH - 1;
   localparam int OUT_WIDTH  = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [SIZE_WIDTH-1:0] MAX_SIZE = SIZE_WIDTH'(MAX_WORDS);
   localparam logic [OUT_WIDTH-1:0]  MAX_OUT  = OUT_WIDTH'(MAX_OUTSTANDING);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
   state_t state, nextState;

   logic [ADDR_WIDTH-1:0] baseAddr;
   logic [SIZE_WIDTH-1:0] sizeReg, issueIdx, recvCount, clampedSize;
   logic [OUT_WIDTH-1:0]  outstanding;
   logic [MAX_WORDS-1:0]  recvMask;
   logic [WORD_WIDTH-1:0] dataWords [MAX_WORDS];
   logic                  epoch;
   logic                  acceptStart, reqFire, lastIssue;
   logic                  rspEpoch, rspCandidate, rspHit;
   logic [SLOT_WIDTH-1:0] rspSlot;

   assign clampedSize   = (size > MAX_SIZE) ? MAX_SIZE : size;
   assign acceptStart   = (state == IDLE) && start;
   assign ready         = (state == IDLE);
   assign valid_out     = (state == DONE);
   assign mem_rsp_ready = 1'b1;

   assign mem_req_valid = (state == ISSUE) && (outstanding < MAX_OUT);
   assign mem_req_addr  = baseAddr + (ADDR_WIDTH'(issueIdx) << 2);
   assign mem_req_tag   = {epoch, SLOT_WIDTH'(issueIdx)};
   assign reqFire       = mem_req_valid && mem_req_ready;
   assign lastIssue     = (issueIdx == sizeReg - SIZE_WIDTH'(1));

   // A response counts only if it belongs to the live fetch: not idle, same epoch, slot in range.
   assign rspEpoch     = mem_rsp_tag[TAG_WIDTH-1];
   assign rspSlot      = mem_rsp_tag[SLOT_WIDTH-1:0];
   assign rspCandidate = mem_rsp_valid && (state != IDLE) && (rspEpoch == epoch)
                         && (SIZE_WIDTH'(rspSlot) < sizeReg);
   assign rspHit       = rspCandidate && !recvMask[rspSlot];

   for (genvar g = 0; g < MAX_WORDS; g++) begin : g_pack
      assign data_out[g*WORD_WIDTH +: WORD_WIDTH] = dataWords[g];
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= nextState;
   end

   // NOTE: nextState gets its default before the case so no path can leave it unassigned (no latch).
   always_comb begin
      nextState = state;
      case (state)
         IDLE:  if (start) nextState = (clampedSize == '0) ? DONE : ISSUE;
         ISSUE: if (reqFire && lastIssue) nextState = WAIT;
         WAIT:  if ((recvCount + SIZE_WIDTH'(rspHit)) == sizeReg) nextState = DONE;
         DONE:  nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   // NOTE: the word buffer is reset because data_out must read zero straight out of reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         baseAddr    <= '0;
         sizeReg     <= '0;
         issueIdx    <= '0;
         recvCount   <= '0;
         recvMask    <= '0;
         outstanding <= '0;
         epoch       <= 1'b0;
         for (int i = 0; i < MAX_WORDS; i++) dataWords[i] <= '0;
      end else if (acceptStart) begin
         baseAddr  <= addr & ~ADDR_WIDTH'(3);
         sizeReg   <= clampedSize;
         issueIdx  <= '0;
         recvCount <= '0;
         recvMask  <= '0;
         epoch     <= ~epoch;
         for (int i = 0; i < MAX_WORDS; i++) dataWords[i] <= '0;
      end else begin
         if (reqFire) issueIdx <= issueIdx + SIZE_WIDTH'(1);
         if (rspHit) begin
            recvMask[rspSlot]  <= 1'b1;
            dataWords[rspSlot] <= mem_rsp_data;
            recvCount          <= recvCount + SIZE_WIDTH'(1);
         end
         if (reqFire && !rspHit)      outstanding <= outstanding + OUT_WIDTH'(1);
         else if (rspHit && !reqFire) outstanding <= outstanding - OUT_WIDTH'(1);
      end
   end

   // A second response for a slot already filled is a cache protocol violation.
   always_ff @(posedge clk) begin
      if (!reset && rspCandidate) assert (!recvMask[rspSlot]);
   end

endmodule

// File: tb/tb_ti_node_fetch.sv
// Directed bench for ti_node_fetch: a small cache model answers requests in
// order, in reverse batches or not at all; expected values are hand-derived.
module tb_ti_node_fetch;

   typedef enum int {RSP_NONE, RSP_INORDER, RSP_REVERSE} rspMode_t;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic [31:0]   addr = '0;
   logic [3:0]    size = '0;
   logic          ready;
   logic [383:0]  data_out;
   logic          valid_out;
   logic          mem_req_valid;
   logic [31:0]   mem_req_addr;
   logic [4:0]    mem_req_tag;
   logic          mem_req_ready = 1'b0;
   logic          mem_rsp_valid = 1'b0;
   logic [31:0]   mem_rsp_data = '0;
   logic [4:0]    mem_rsp_tag = '0;
   logic          mem_rsp_ready;

   ti_node_fetch #(
      .ADDR_WIDTH(32), .WORD_WIDTH(32), .MAX_WORDS(12), .MAX_OUTSTANDING(4), .TAG_WIDTH(5)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .addr(addr), .size(size), .ready(ready),
      .data_out(data_out), .valid_out(valid_out),
      .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_tag(mem_req_tag),
      .mem_req_ready(mem_req_ready), .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
      .mem_rsp_tag(mem_rsp_tag), .mem_rsp_ready(mem_rsp_ready)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   // Cache model and expectation state
   rspMode_t    rspMode = RSP_NONE;
   logic [4:0]  pending[$];
   logic [4:0]  stale[$];
   logic [31:0] reqLog [16];
   logic [31:0] expBase = '0;
   logic [31:0] dataBase = '0;
   logic        expEpoch = 1'b0;
   logic        cacheReady = 1'b1;
   logic        draining = 1'b0;
   logic        injValid = 1'b0;
   logic [4:0]  injTag = '0;
   logic [31:0] injData = '0;
   int expSize = 0, issued = 0, inFlight = 0, maxInFlight = 0;
   int validCount = 0, validCyc = 0, startCyc = 0, firstReqCyc = 0, lastReqCyc = 0;
   int stallAt = 0, stallLen = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   // One clock cycle: observe at the falling edge, drive the cache side, then step past the rising edge.
   task automatic tick();
      logic [4:0] t;
      logic       stalled;
      @(negedge clk);
      if (valid_out) begin
         validCount++;
         validCyc = cyc;
      end
      if (start && ready) startCyc = cyc;

      mem_rsp_valid = 1'b0;
      mem_rsp_tag   = '0;
      mem_rsp_data  = '0;
      if (injValid) begin
         mem_rsp_valid = 1'b1;
         mem_rsp_tag   = injTag;
         mem_rsp_data  = injData;
         injValid      = 1'b0;
      end else if (pending.size() > 0 && rspMode != RSP_NONE) begin
         if (rspMode == RSP_REVERSE && (pending.size() >= 4 || issued == expSize)) draining = 1'b1;
         if (rspMode == RSP_INORDER || draining) begin
            t = (rspMode == RSP_INORDER) ? pending.pop_front() : pending.pop_back();
            mem_rsp_valid = 1'b1;
            mem_rsp_tag   = t;
            mem_rsp_data  = dataBase + 32'(t[3:0]);
            inFlight--;
         end
         if (pending.size() == 0) draining = 1'b0;
      end

      stalled = (stallLen > 0) && (issued == stallAt);
      mem_req_ready = cacheReady && !stalled;
      if (stalled) begin
         stallLen--;
         check("stall_valid", 32'(mem_req_valid), 32'd1);
         check("stall_addr", mem_req_addr, expBase + 32'(issued) * 4);
         check("stall_tag", 32'(mem_req_tag), 32'({expEpoch, issued[3:0]}));
      end
      if (mem_req_valid && mem_req_ready) begin
         check("req_in_range", 32'(issued < expSize), 32'd1);
         check("req_addr", mem_req_addr, expBase + 32'(issued) * 4);
         check("req_tag", 32'(mem_req_tag), 32'({expEpoch, issued[3:0]}));
         if (issued < 16) reqLog[issued] = mem_req_addr;
         if (issued == 0) firstReqCyc = cyc;
         lastReqCyc = cyc;
         pending.push_back(mem_req_tag);
         issued++;
         inFlight++;
         if (inFlight > maxInFlight) maxInFlight = inFlight;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic launch(input logic [31:0] a, input int n, input rspMode_t m, input logic [31:0] db);
      expBase     = a & ~32'h3;
      expSize     = (n > 12) ? 12 : n;
      issued      = 0;
      validCount  = 0;
      inFlight    = 0;
      maxInFlight = 0;
      draining    = 1'b0;
      pending.delete();
      rspMode     = m;
      dataBase    = db;
      expEpoch    = ~expEpoch;
      addr        = a;
      size        = 4'(n);
      start       = 1'b1;
      tick();
      start       = 1'b0;
   endtask

   // Bounded wait for valid_out, then one more cycle to confirm a single pulse and ready again.
   task automatic waitDone(input string tag);
      for (int n = 0; n < 300 && validCount == 0; n++) tick();
      tick();
      check({tag, "_pulses"}, 32'(validCount), 32'd1);
      check({tag, "_ready"}, 32'(ready), 32'd1);
   endtask

   task automatic checkWords(input string tag, input logic [31:0] db, input int n);
      for (int i = 0; i < 12; i++)
         check($sformatf("%s_w%0d", tag, i), data_out[i*32 +: 32], (i < n) ? db + 32'(i) : 32'd0);
   endtask

   initial begin
      reset = 1'b1;
      repeat (3) tick();
      check("rst_ready", 32'(ready), 32'd1);
      check("rst_valid_out", 32'(valid_out), 32'd0);
      check("rst_req_valid", 32'(mem_req_valid), 32'd0);
      check("rst_data_zero", 32'(|data_out), 32'd0);
      check("rst_rsp_ready", 32'(mem_rsp_ready), 32'd1);
      reset = 1'b0;
      tick();

      // size 8, in-order one-cycle responses
      launch(32'h1000, 8, RSP_INORDER, 32'hA0);
      waitDone("t1");
      check("t1_latency", 32'(validCyc - startCyc), 32'd10);
      check("t1_first_req", 32'(firstReqCyc - startCyc), 32'd1);
      check("t1_last_req", 32'(lastReqCyc - startCyc), 32'd8);
      check("t1_reqs", 32'(issued), 32'd8);
      checkWords("t1", 32'hA0, 8);

      // size 12, responses returned in reverse batches
      launch(32'h3000, 12, RSP_REVERSE, 32'h300);
      waitDone("t2");
      check("t2_reqs", 32'(issued), 32'd12);
      check("t2_max_inflight", 32'(maxInFlight), 32'd4);
      checkWords("t2", 32'h300, 12);

      // oversize request is clamped to 12 words
      launch(32'h5000, 15, RSP_INORDER, 32'h500);
      waitDone("t3");
      check("t3_reqs", 32'(issued), 32'd12);
      checkWords("t3", 32'h500, 12);

      // size 1 with unaligned base, then size 0
      launch(32'h2003, 1, RSP_INORDER, 32'h200);
      waitDone("t4");
      check("t4_reqs", 32'(issued), 32'd1);
      check("t4_req_addr", reqLog[0], 32'h2000);
      checkWords("t4", 32'h200, 1);
      launch(32'h8000, 0, RSP_INORDER, 32'h0);
      waitDone("t5");
      check("t5_latency", 32'(validCyc - startCyc), 32'd1);
      check("t5_reqs", 32'(issued), 32'd0);
      check("t5_data_zero", 32'(|data_out), 32'd0);

      // five-cycle request stall after word 3, plus a start pulse that must be ignored
      stallAt  = 3;
      stallLen = 5;
      launch(32'h4000, 8, RSP_INORDER, 32'h400);
      tick();
      addr  = 32'h9000;
      size  = 4'd3;
      start = 1'b1;
      tick();
      start = 1'b0;
      waitDone("t6");
      check("t6_stall_used", 32'(stallLen), 32'd0);
      check("t6_reqs", 32'(issued), 32'd8);
      checkWords("t6", 32'h400, 8);

      // reset after 3 of 8 words; stale responses afterwards must be dropped
      launch(32'h6000, 8, RSP_NONE, 32'h600);
      for (int n = 0; n < 50 && issued < 3; n++) tick();
      check("t7_reached3", 32'(issued), 32'd3);
      cacheReady = 1'b0;
      reset = 1'b1;
      repeat (2) tick();
      reset = 1'b0;
      cacheReady = 1'b1;
      expEpoch = 1'b0;
      stale = pending;
      pending.delete();
      inFlight = 0;
      tick();
      check("t7_rst_ready", 32'(ready), 32'd1);
      check("t7_rst_req_valid", 32'(mem_req_valid), 32'd0);
      check("t7_rst_data_zero", 32'(|data_out), 32'd0);
      foreach (stale[k]) begin
         injValid = 1'b1;
         injTag   = stale[k];
         injData  = 32'hDEAD0000 + 32'(k);
         tick();
      end
      check("t7_stale_ready", 32'(ready), 32'd1);
      check("t7_stale_data_zero", 32'(|data_out), 32'd0);
      launch(32'h7000, 2, RSP_NONE, 32'h700);
      tick();
      injValid = 1'b1;
      injTag   = {~expEpoch, 4'd0};
      injData  = 32'hBAD0;
      tick();
      injValid = 1'b1;
      injTag   = {expEpoch, 4'd5};
      injData  = 32'hBAD5;
      tick();
      rspMode = RSP_INORDER;
      waitDone("t7");
      check("t7_reqs", 32'(issued), 32'd2);
      checkWords("t7", 32'h700, 2);

      // request addresses wrap past the top of the address space
      launch(32'hFFFF_FFF8, 4, RSP_INORDER, 32'hF00);
      waitDone("t8");
      check("t8_reqs", 32'(issued), 32'd4);
      check("t8_addr0", reqLog[0], 32'hFFFF_FFF8);
      check("t8_addr1", reqLog[1], 32'hFFFF_FFFC);
      check("t8_addr2", reqLog[2], 32'h0000_0000);
      check("t8_addr3", reqLog[3], 32'h0000_0004);
      checkWords("t8", 32'hF00, 4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not complete");
      $fatal(1);
   end

endmodule
